// File: rtl/shared_count_arbiter_if.sv
// Handshake bundle between the requesting control blocks and the shared counter
// arbiter. Requesters drive req/len; the arbiter drives grant, completion and
// observation signals.
interface shared_count_arbiter_if #(
  parameter int NREQ = 4,
  parameter int CW   = 4
);
  logic [NREQ-1:0]    req;
  logic [NREQ*CW-1:0] len;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic               busy;
  logic [CW-1:0]      count;

  modport master (
    output req, len,
    input  gnt, done, busy, count
  );

  modport slave (
    input  req, len,
    output gnt, done, busy, count
  );
endinterface

// File: rtl/shared_count_arbiter.sv
// Round-robin arbiter that lends one up-counter to NREQ requesters in turn.
// The winner's len is captured at grant; the count runs 0..len, then the
// owner gets a one-cycle done pulse. All outputs come straight from flops.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | no owner; search req from last+1 round-robin and grant winner
//   RUN   | counter owned; count up to target, abort if owner drops req
//   DONE  | done pulse to owner; release grant unconditionally
module shared_count_arbiter #(
  parameter int NREQ = 4,
  parameter int CW   = 4
) (
  input logic                   clk,
  input logic                   rst,
  shared_count_arbiter_if.slave bus
);
  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_d;
  logic [OW-1:0]   owner, owner_d;
  logic [OW-1:0]   last, last_d;
  logic [OW-1:0]   winner;
  logic            found;
  logic [CW-1:0]   target, target_d;
  logic [CW-1:0]   count_q, count_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            busy_q, busy_d;
  logic [CW-1:0]   len_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_len
    assign len_arr[i] = bus.len[i*CW +: CW];
  end

  // Round-robin search: first set req starting just after the last winner.
  always_comb begin
    int            idx;
    logic [OW-1:0] idx_w;
    found  = 1'b0;
    winner = last;
    idx    = 0;
    idx_w  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(last) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_w = OW'(idx);
      if (!found && bus.req[idx_w]) begin
        found  = 1'b1;
        winner = idx_w;
      end
    end
  end

  // State and datapath registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      owner   <= '0;
      last    <= OW'(NREQ - 1);
      target  <= '0;
      count_q <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_d;
      owner   <= owner_d;
      last    <= last_d;
      target  <= target_d;
      count_q <= count_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state decision.
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (found) state_d = RUN;
      RUN: begin
        if (!bus.req[owner])       state_d = IDLE;
        else if (count_q == target) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and transaction context.
  always_comb begin
    owner_d  = owner;
    last_d   = last;
    target_d = target;
    count_d  = count_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    unique case (state)
      IDLE: begin
        gnt_d   = '0;
        count_d = '0;
        if (found) begin
          owner_d  = winner;
          last_d   = winner;
          target_d = len_arr[winner];
          gnt_d[winner] = 1'b1;
        end
      end
      RUN: begin
        if (!bus.req[owner]) begin
          // Abort: release without a done pulse; last stays on this owner.
          gnt_d   = '0;
          count_d = '0;
        end else if (count_q == target) begin
          done_d[owner] = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      DONE: begin
        gnt_d   = '0;
        count_d = '0;
      end
      default: begin
        gnt_d   = '0;
        count_d = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  assign bus.gnt   = gnt_q;
  assign bus.done  = done_q;
  assign bus.busy  = busy_q;
  assign bus.count = count_q;
endmodule

// File: tb/tb_shared_count_arbiter.sv
// Bench for shared_count_arbiter: directed scenarios followed by random
// request traffic, every cycle compared against a transaction-age model.
module tb_shared_count_arbiter;
  localparam int NREQ = 4;
  localparam int CW   = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  shared_count_arbiter_if #(.NREQ(NREQ), .CW(CW)) bus ();

  shared_count_arbiter #(.NREQ(NREQ), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Model: a transaction is alive for len+2 cycles after its grant edge;
  // age counts edges since the grant.
  bit m_act;
  int m_owner, m_len, m_age, m_last;

  int              grant_log[$];
  logic [NREQ-1:0] prev_gnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int idx;
    if (rst) begin
      m_act  = 1'b0;
      m_last = NREQ - 1;
    end else if (m_act) begin
      if (m_age <= m_len) begin
        if (!bus.req[m_owner]) m_act = 1'b0;
        else m_age++;
      end else begin
        m_act = 1'b0;
      end
    end else if (bus.req != '0) begin
      for (int k = 1; k <= NREQ; k++) begin
        idx = (m_last + k) % NREQ;
        if (!m_act && bus.req[idx]) begin
          m_act   = 1'b1;
          m_owner = idx;
          m_last  = idx;
          m_len   = int'(bus.len[idx*CW +: CW]);
          m_age   = 0;
        end
      end
    end
  endtask

  task automatic tick();
    logic [NREQ-1:0] exp_gnt, exp_done;
    int exp_count;
    model_step();
    @(posedge clk);
    #1;
    exp_gnt   = '0;
    exp_done  = '0;
    exp_count = 0;
    if (m_act) begin
      exp_gnt[m_owner] = 1'b1;
      exp_count = (m_age > m_len) ? m_len : m_age;
      if (m_age == m_len + 1) exp_done[m_owner] = 1'b1;
    end
    check("gnt",   32'(bus.gnt),   32'(exp_gnt));
    check("done",  32'(bus.done),  32'(exp_done));
    check("busy",  32'(bus.busy),  32'(m_act));
    check("count", 32'(bus.count), 32'(exp_count));
    if (bus.gnt != '0 && prev_gnt == '0) begin
      for (int i = 0; i < NREQ; i++)
        if (bus.gnt[i]) grant_log.push_back(i);
    end
    prev_gnt = bus.gnt;
  endtask

  task automatic set_len(input int i, input int v);
    bus.len[i*CW +: CW] = CW'(v);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (bus.busy && n < budget) begin
      tick();
      n++;
    end
    check("wait_idle", 32'(bus.busy), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    bus.req  = '0;
    bus.len  = '0;
    prev_gnt = '0;
    m_act    = 1'b0;
    m_owner  = 0;
    m_len    = 0;
    m_age    = 0;
    m_last   = NREQ - 1;

    // Reset state
    tick();
    tick();
    check("rst_gnt",   32'(bus.gnt),   32'd0);
    check("rst_count", 32'(bus.count), 32'd0);
    rst = 1'b0;

    // Single request, len0=3
    set_len(0, 3);
    bus.req = 4'b0001;
    tick();
    check("t1_gnt", 32'(bus.gnt), 32'h1);
    repeat (3) tick();
    check("t1_count3", 32'(bus.count), 32'd3);
    tick();
    check("t1_done", 32'(bus.done), 32'h1);
    bus.req = 4'b0000;
    tick();
    check("t1_release", 32'(bus.gnt), 32'd0);
    tick();

    // Round-robin fairness from reset, all len=1
    do_reset();
    grant_log.delete();
    for (int i = 0; i < NREQ; i++) set_len(i, 1);
    bus.req = 4'b1111;
    repeat (20) tick();
    check("rr_ngrants", 32'(grant_log.size()), 32'd5);
    if (grant_log.size() >= 5) begin
      check("rr_g0", 32'(grant_log[0]), 32'd0);
      check("rr_g1", 32'(grant_log[1]), 32'd1);
      check("rr_g2", 32'(grant_log[2]), 32'd2);
      check("rr_g3", 32'(grant_log[3]), 32'd3);
      check("rr_g4", 32'(grant_log[4]), 32'd0);
    end
    bus.req = 4'b0000;
    wait_idle(10);
    tick();

    // len=0
    set_len(0, 0);
    bus.req = 4'b0001;
    tick();
    tick();
    check("len0_done",  32'(bus.done),  32'h1);
    check("len0_count", 32'(bus.count), 32'd0);
    bus.req = 4'b0000;
    tick();
    tick();

    // len=15
    set_len(0, 15);
    bus.req = 4'b0001;
    tick();
    repeat (15) tick();
    check("len15_count", 32'(bus.count), 32'd15);
    tick();
    check("len15_done",  32'(bus.done),  32'h1);
    check("len15_hold",  32'(bus.count), 32'd15);
    bus.req = 4'b0000;
    tick();
    check("len15_release", 32'(bus.gnt), 32'd0);
    tick();

    // Abort of requester 0 at count=2, requester 1 pending
    do_reset();
    set_len(0, 6);
    set_len(1, 2);
    bus.req = 4'b0011;
    tick();
    check("ab_gnt0", 32'(bus.gnt), 32'h1);
    repeat (2) tick();
    check("ab_count2", 32'(bus.count), 32'd2);
    bus.req = 4'b0010;
    tick();
    check("ab_gnt_off", 32'(bus.gnt),   32'd0);
    check("ab_count0",  32'(bus.count), 32'd0);
    check("ab_nodone",  32'(bus.done),  32'd0);
    tick();
    check("ab_gnt1", 32'(bus.gnt), 32'h2);
    repeat (3) tick();
    check("ab_done1", 32'(bus.done), 32'h2);
    bus.req = 4'b0000;
    tick();
    tick();

    // Reset mid-run at count=4
    set_len(0, 8);
    bus.req = 4'b0001;
    tick();
    repeat (4) tick();
    check("mr_count4", 32'(bus.count), 32'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr_gnt",   32'(bus.gnt),   32'd0);
    check("mr_done",  32'(bus.done),  32'd0);
    check("mr_busy",  32'(bus.busy),  32'd0);
    check("mr_count", 32'(bus.count), 32'd0);
    bus.req = 4'b0100;
    tick();
    check("mr_gnt2", 32'(bus.gnt), 32'h4);
    bus.req = 4'b0000;
    tick();
    tick();

    // len sampled only at grant
    set_len(1, 5);
    bus.req = 4'b0010;
    tick();
    check("ls_gnt1", 32'(bus.gnt), 32'h2);
    set_len(1, 2);
    repeat (5) tick();
    check("ls_count5", 32'(bus.count), 32'd5);
    tick();
    check("ls_done", 32'(bus.done), 32'h2);
    bus.req = 4'b0000;
    tick();
    tick();

    // Random traffic
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!bus.req[i]) begin
          if ($urandom_range(3) == 0) begin
            bus.req[i] = 1'b1;
            set_len(i, int'($urandom_range(15)));
          end
        end else if (prev_gnt[i] == 1'b0 && bus.done[i] == 1'b0) begin
          if ($urandom_range(7) == 0) set_len(i, int'($urandom_range(15)));
        end
        if (bus.req[i] && bus.done[i]) bus.req[i] = 1'b0;
        else if (bus.req[i] && $urandom_range(49) == 0) bus.req[i] = 1'b0;
      end
      rst = ($urandom_range(199) == 0);
      tick();
    end
    rst = 1'b0;
    bus.req = '0;
    wait_idle(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
